instr_loader: RTL and testbench
===============================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, instruction-memory word-address width.
REQ-002 Parameter BASE_ADDR, default 0, first word address written after start.
REQ-003 clk  in  1  sole clock, all logic on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 start  in  1  one-cycle pulse beginning a load session.
REQ-006 in_valid, in_ready  in, out  1 each  field-beat handshake; a beat transfers when both are high on a rising edge.
REQ-007 in_opcode 7, in_fmt 3 (Imm=0, UpperImm=1, Store=2, Branch=3, Jump=4), in_rd/in_rs1/in_rs2 5 each, in_funct3 3, in_funct7 7, in_imm 32, in_last 1  in  instruction fields.
REQ-008 mem_we  out  1, mem_addr  out  ADDR_WIDTH, mem_wdata  out  32  instruction-memory write port.
REQ-009 busy  out  1, done  out  1, err  out  1, count  out  ADDR_WIDTH+1  session status.

Function
REQ-010 FSM states IDLE, LOAD, DONE; IDLE->LOAD on start; LOAD->DONE on write of an in_last beat or on error; DONE->LOAD on start; start in LOAD ignored.
REQ-011 in_ready is high only in LOAD and low in the cycle after a beat with in_last or an error is accepted.
REQ-012 Latency: a beat accepted at edge N is written with mem_we high for exactly one cycle after edge N+1; one beat per cycle at full throughput.
REQ-013 Opcode 0110011 encodes R: funct7|rs2|rs1|funct3|rd|opcode, in_fmt ignored.
REQ-014 Imm: imm[11:0]|rs1|funct3|rd|opcode.
REQ-015 Store: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
REQ-016 Branch: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
REQ-017 UpperImm: imm[31:12]|rd|opcode.
REQ-018 Jump: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
REQ-019 mem_addr starts at BASE_ADDR each session and increments by 1 per write, wrapping modulo 2^ADDR_WIDTH.
REQ-020 count resets to 0 on start and increments per write; when count reaches 2^ADDR_WIDTH without in_last, err sets and FSM enters DONE.
REQ-021 done is high in DONE; busy is high in LOAD or while a write is pending.
REQ-022 err is sticky until the next start or rst.
REQ-023 start coincident with the final write from DONE: the write completes first, new session begins at BASE_ADDR the next cycle.

Reset
REQ-024 rst forces IDLE; in_ready, mem_we, busy, done, err = 0; mem_addr = BASE_ADDR; count, mem_wdata = 0.
REQ-025 rst mid-session drops any pending write with no mem_we pulse; rst dominates start.

Configuration
REQ-026 Macro INSTR_LOADER_CHECK_EN defined: opcode outside {0110011, 0000011, 0010011, 0100011, 1100011, 0010111, 0110111, 1100111, 1101111}, or in_fmt above 4 on a non-R opcode, sets err, suppresses that write and enters DONE.
REQ-027 Macro undefined: no legality checks; in_fmt above 4 encodes as Imm; err is raised only by overflow.

Verification
REQ-028 start, beat op 0010011 Imm rd=1 rs1=0 f3=0 imm=5 last -> mem_we at addr 0, wdata 0x00500093, done=1, count=1.
REQ-029 Back-to-back beats sw x2,8(x1) (op 0100011 Store f3=2) then jal x1,8 (op 1101111 Jump) with last -> wdata 0x0020A423 then 0x008000EF at consecutive addresses, in_ready held high.
REQ-030 Beat op 0110011 rd=3 rs1=1 rs2=2 f3=0 f7=0 with in_fmt=Store -> wdata 0x002081B3.
REQ-031 ADDR_WIDTH=2, BASE_ADDR=2, four beats without last -> addrs 2,3,0,1; err=1, done=1, count=4.
REQ-032 INSTR_LOADER_CHECK_EN defined, beat opcode 1111111 -> no mem_we, err=1, done=1; undefined -> write occurs, err=0.
REQ-033 rst asserted the cycle after a beat is accepted -> no mem_we, all outputs at reset values the next cycle.

Source files
------------

// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//   Accepts decoded RV32 instruction fields one beat at a time, packs each beat
//   into a 32-bit instruction word and writes it into an instruction memory at
//   consecutive word addresses starting from BASE_ADDR.
//
//   Optional feature: define INSTR_LOADER_CHECK_EN to enable opcode / format
//   legality checks. An illegal beat raises err, is not written and ends the
//   session. Without the macro no legality checks are made and format codes
//   above 4 encode as Imm.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   start             : one-cycle pulse, opens a load session (IDLE/DONE only)
//   in_valid/in_ready : field-beat handshake
//   in_opcode..in_last: instruction fields of the current beat
//   mem_we/mem_addr/mem_wdata : instruction-memory write port
//   busy, done, err, count    : session status
//   dbg_state         : current FSM state (0 IDLE, 1 LOAD, 2 DONE)
//
// Handshake: a beat transfers on a rising edge where in_valid and in_ready are
// both high. in_valid may be raised at any time; in_ready depends only on the
// FSM state, never on in_valid.
// -----------------------------------------------------------------------------
module instr_loader #(
  parameter int          ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            in_opcode,
  input  logic [2:0]            in_fmt,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic [31:0]           in_imm,
  input  logic                  in_last,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   count,
  output logic [1:0]            dbg_state
);

  localparam logic [6:0]            OP_R     = 7'b0110011;
  localparam logic [ADDR_WIDTH-1:0] L_BASE   = ADDR_WIDTH'(BASE_ADDR);
  // Accepted-beat count just before the final slot of the address space.
  localparam logic [ADDR_WIDTH:0]   L_LAST_SLOT = {1'b0, {ADDR_WIDTH{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [ADDR_WIDTH:0]   r_acc;        // beats accepted for writing this session
  logic                  r_err;
  logic                  r_s1_valid;   // stage 1: encoded word captured
  logic [31:0]           r_s1_word;
  logic                  r_we;         // stage 2: write presented to memory
  logic [31:0]           r_wdata;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_next;       // address for the next issued write
  logic [ADDR_WIDTH:0]   r_count;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_illegal;
  logic                  w_ovf;
  logic                  w_write_beat;
  logic                  w_start_ok;
  logic [31:0]           w_word;

  assign w_ready      = (r_state == S_LOAD);
  assign w_accept     = in_valid && w_ready;
  assign w_write_beat = w_accept && !w_illegal;
  // This beat fills the last free address without closing the session.
  assign w_ovf        = !in_last && (r_acc == L_LAST_SLOT);
  // start is honoured only outside LOAD.
  assign w_start_ok   = start && (r_state != S_LOAD);

  // ---------------------------------------------------------------------------
  // Field packing
  // ---------------------------------------------------------------------------
  always_comb begin
    w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
    if (in_opcode == OP_R) begin
      w_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
    end else begin
      case (in_fmt)
        3'd1: w_word = {in_imm[31:12], in_rd, in_opcode};
        3'd2: w_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                        in_imm[4:0], in_opcode};
        3'd3: w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                        in_imm[4:1], in_imm[11], in_opcode};
        3'd4: w_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                        in_rd, in_opcode};
        default: w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Legality
  // ---------------------------------------------------------------------------
`ifdef INSTR_LOADER_CHECK_EN
  always_comb begin
    w_illegal = 1'b0;
    case (in_opcode)
      7'b0110011, 7'b0000011, 7'b0010011, 7'b0100011, 7'b1100011,
      7'b0010111, 7'b0110111, 7'b1100111, 7'b1101111:
        w_illegal = (in_opcode != OP_R) && (in_fmt > 3'd4);
      default:
        w_illegal = 1'b1;
    endcase
  end
`else
  assign w_illegal = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_LOAD;
      S_LOAD: if (w_accept && (in_last || w_illegal || w_ovf)) w_state_nxt = S_DONE;
      S_DONE: if (start) w_state_nxt = S_LOAD;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: accept (edge N) -> stage 1 -> write issued at edge N+1.
  // A start arriving while an old write is still in flight lets that write
  // finish at its own address; only the address/count of the new session
  // restart from BASE_ADDR / 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_err      <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_word  <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_addr     <= L_BASE;
      r_next     <= L_BASE;
      r_count    <= '0;
    end else begin
      r_s1_valid <= w_write_beat;
      if (w_write_beat) r_s1_word <= w_word;
      r_we <= r_s1_valid;
      if (r_s1_valid) begin
        r_wdata <= r_s1_word;
        r_addr  <= r_next;
      end
      if (w_start_ok) begin
        r_acc   <= '0;
        r_err   <= 1'b0;
        r_next  <= L_BASE;
        r_count <= '0;
      end else begin
        if (w_write_beat) r_acc <= r_acc + (ADDR_WIDTH+1)'(1);
        if (w_accept && (w_illegal || w_ovf)) r_err <= 1'b1;
        if (r_s1_valid) begin
          r_next  <= r_next + ADDR_WIDTH'(1);
          r_count <= r_count + (ADDR_WIDTH+1)'(1);
        end
      end
    end
  end

  assign in_ready  = w_ready;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = (r_state == S_LOAD) || r_s1_valid || r_we;
  assign done      = (r_state == S_DONE);
  assign err       = r_err;
  assign count     = r_count;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_instr_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_loader
//   Directed and randomized checks of instr_loader against a queue-based
//   reference model. Main instance: ADDR_WIDTH=8, BASE_ADDR=0. Second instance
//   (ADDR_WIDTH=2, BASE_ADDR=2) exercises address wrap and overflow.
// -----------------------------------------------------------------------------
module tb_instr_loader;

  localparam int AW = 8;
  localparam int W  = 56;   // {cycle[15:0], addr[7:0], data[31:0]}

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst, start, in_valid, in_last;
  logic [6:0]  in_opcode, in_funct7;
  logic [2:0]  in_fmt, in_funct3;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;

  logic          in_ready, mem_we, busy, done, err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;
  logic [1:0]    dbg_state;

  logic        s_start, s_valid, s_ready, s_we, s_busy, s_done, s_err;
  logic [1:0]  s_addr, s_dbg;
  logic [31:0] s_wdata;
  logic [2:0]  s_count;

  instr_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_fmt(in_fmt), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .count(count), .dbg_state(dbg_state)
  );

  instr_loader #(.ADDR_WIDTH(2), .BASE_ADDR(2)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .in_valid(s_valid), .in_ready(s_ready),
    .in_opcode(in_opcode), .in_fmt(in_fmt), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .in_last(in_last), .mem_we(s_we), .mem_addr(s_addr), .mem_wdata(s_wdata),
    .busy(s_busy), .done(s_done), .err(s_err), .count(s_count), .dbg_state(s_dbg)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [6:0] legal_ops [9] = '{7'h33, 7'h03, 7'h13, 7'h23, 7'h63,
                                7'h17, 7'h37, 7'h67, 7'h6f};

  logic [W-1:0] exp_q[$];
  bit m_load = 0, m_done = 0, m_err = 0;
  int m_n = 0;

  function automatic logic [31:0] ref_enc(input logic [6:0] op, input logic [2:0] fmt,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    logic [31:0] o, d, s1, s2, t3, i;
    o = 32'(op); d = 32'(rd); s1 = 32'(rs1); s2 = 32'(rs2); t3 = 32'(f3); i = imm;
    if (op == 7'h33)
      return o | (d << 7) | (t3 << 12) | (s1 << 15) | (s2 << 20) | (32'(f7) << 25);
    case (fmt)
      3'd1: return o | (d << 7) | (i & 32'hFFFF_F000);
      3'd2: return o | ((i & 32'h1F) << 7) | (t3 << 12) | (s1 << 15) | (s2 << 20)
                   | (((i >> 5) & 32'h7F) << 25);
      3'd3: return o | (((i >> 11) & 32'h1) << 7) | (((i >> 1) & 32'hF) << 8)
                   | (t3 << 12) | (s1 << 15) | (s2 << 20)
                   | (((i >> 5) & 32'h3F) << 25) | (((i >> 12) & 32'h1) << 31);
      3'd4: return o | (d << 7) | (((i >> 12) & 32'hFF) << 12)
                   | (((i >> 11) & 32'h1) << 20) | (((i >> 1) & 32'h3FF) << 21)
                   | (((i >> 20) & 32'h1) << 31);
      default: return o | (d << 7) | (t3 << 12) | (s1 << 15) | ((i & 32'hFFF) << 20);
    endcase
  endfunction

  function automatic bit ref_illegal(input logic [6:0] op, input logic [2:0] fmt);
`ifdef INSTR_LOADER_CHECK_EN
    bit known = 0;
    foreach (legal_ops[k]) if (legal_ops[k] == op) known = 1;
    return !known || (op != 7'h33 && fmt > 3'd4);
`else
    return (op === 7'hxx) && (fmt === 3'hx);  // never true: no checks
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboards
  // ---------------------------------------------------------------------------
  logic [31:0] last_wdata = '0;
  logic [AW-1:0] last_addr = '0;
  logic [1:0] got2_q[$];

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_write", 64'(mem_we), 64'd0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("write", 64'({16'(cyc), mem_addr, mem_wdata}), 64'(e));
      end
      last_wdata = mem_wdata;
      last_addr  = mem_addr;
    end
    if (s_we === 1'b1) got2_q.push_back(s_addr);
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a falling edge, return at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (!m_load) begin
      m_load = 1; m_done = 0; m_err = 0; m_n = 0;
    end
  endtask

  task automatic model_beat(input logic [6:0] op, input logic [2:0] fmt,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm, input bit last);
    if (ref_illegal(op, fmt)) begin
      m_err = 1; m_load = 0; m_done = 1;
    end else begin
      exp_q.push_back({16'(cyc + 1), AW'(m_n), ref_enc(op, fmt, rd, rs1, rs2, f3, f7, imm)});
      m_n++;
      if (last) begin
        m_load = 0; m_done = 1;
      end else if (m_n == (1 << AW)) begin
        m_err = 1; m_load = 0; m_done = 1;
      end
    end
  endtask

  task automatic send_beat(input logic [6:0] op, input logic [2:0] fmt,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm, input bit last);
    bit acc = 0;
    in_opcode = op; in_fmt = fmt; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    for (int w = 0; w < 8 && !acc; w++) begin
      acc = (in_ready === 1'b1);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!acc) check("beat_accept", 64'd0, 64'd1);
    else model_beat(op, fmt, rd, rs1, rs2, f3, f7, imm, last);
  endtask

  task automatic send_random(input bit last);
    logic [6:0] op;
    logic [2:0] fmt;
    int r;
    r = $urandom_range(0, 11);
    op = (r < 9) ? legal_ops[r] : 7'($urandom);
    fmt = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
    send_beat(op, fmt, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
              7'($urandom), $urandom, last);
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      check("drain", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic status(input string tag);
    check({tag, "_done"},  64'(done),     64'(m_done));
    check({tag, "_err"},   64'(err),      64'(m_err));
    check({tag, "_count"}, 64'(count),    64'(m_n));
    check({tag, "_busy"},  64'(busy),     64'(m_load));
    check({tag, "_ready"}, 64'(in_ready), 64'(m_load));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    s_start = 1'b0; s_valid = 1'b0;
    in_opcode = '0; in_fmt = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_we",    64'(mem_we),   64'd0);
    check("rst_busy",  64'(busy),     64'd0);
    check("rst_done",  64'(done),     64'd0);
    check("rst_err",   64'(err),      64'd0);
    check("rst_addr",  64'(mem_addr), 64'd0);
    check("rst_count", 64'(count),    64'd0);
    check("rst_wdata", 64'(mem_wdata), 64'd0);
    check("rst_small_addr", 64'(s_addr), 64'd2);
    rst = 1'b0;
    @(negedge clk);

    // addi x1, x0, 5
    do_start();
    send_beat(7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1);
    drain();
    check("addi_wdata", 64'(last_wdata), 64'h0050_0093);
    check("addi_addr",  64'(last_addr),  64'd0);
    status("addi");

    // sw x2,8(x1) then jal x1,8 back to back
    do_start();
    send_beat(7'h23, 3'd2, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b0);
    check("b2b_ready", 64'(in_ready), 64'd1);
    send_beat(7'h6f, 3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b1);
    drain();
    check("jal_wdata", 64'(last_wdata), 64'h0080_00EF);
    check("jal_addr",  64'(last_addr),  64'd1);
    status("b2b");

    // R-type ignores in_fmt
    do_start();
    send_beat(7'h33, 3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, $urandom, 1'b1);
    drain();
    check("rtype_wdata", 64'(last_wdata), 64'h0020_81B3);
    status("rtype");

    // Unknown opcode: written only without legality checks
    do_start();
    send_beat(7'h7f, 3'd0, 5'd4, 5'd5, 5'd6, 3'd1, 7'd0, 32'd3, 1'b1);
    drain();
    status("badop");

    // Reset the cycle after a beat is accepted: the write is dropped
    do_start();
    send_beat(7'h13, 3'd0, 5'd7, 5'd7, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0);
    rst = 1'b1;
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    m_load = 0; m_done = 0; m_err = 0; m_n = 0;
    @(negedge clk);
    check("midrst_we",    64'(mem_we),    64'd0);
    check("midrst_addr",  64'(mem_addr),  64'd0);
    check("midrst_wdata", 64'(mem_wdata), 64'd0);
    status("midrst");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_quiet", 64'(exp_q.size()), 64'd0);

    // Overflow of the main instance: 2^AW beats without last
    do_start();
    for (int i = 0; i < (1 << AW); i++) begin
      send_beat(legal_ops[$urandom_range(0, 8)], 3'($urandom_range(0, 4)),
                5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
                7'($urandom), $urandom, 1'b0);
      if (!m_load) break;
    end
    drain();
    status("ovf");

    // Small instance: wrap 2,3,0,1 then overflow
    in_opcode = 7'h13; in_fmt = 3'd0; in_last = 1'b0;
    s_start = 1'b1;
    @(posedge clk); @(negedge clk);
    s_start = 1'b0;
    s_valid = 1'b1;
    repeat (6) @(negedge clk);
    s_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("wrap_nwrites", 64'(got2_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < got2_q.size(); i++)
      check($sformatf("wrap_addr%0d", i), 64'(got2_q[i]), 64'((2 + i) % 4));
    check("wrap_err",   64'(s_err),   64'd1);
    check("wrap_done",  64'(s_done),  64'd1);
    check("wrap_count", 64'(s_count), 64'd4);
    check("wrap_ready", 64'(s_ready), 64'd0);

    // Randomized sessions, sometimes restarting while the last write is in flight
    for (int s = 0; s < 30; s++) begin
      int nb;
      do_start();
      nb = $urandom_range(1, 6);
      for (int b = 0; b < nb && m_load; b++) begin
        if ($urandom_range(0, 7) == 0) do_start();   // ignored while loading
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send_random(b == nb - 1);
      end
      if ($urandom_range(0, 1) == 0) begin
        drain();
        status($sformatf("rnd%0d", s));
      end else begin
        repeat ($urandom_range(0, 1)) @(negedge clk);
      end
    end
    drain();
    status("rnd_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
